stack_control_fsm: RTL and testbench
====================================

STACK_CONTROL_FSM -- requirements
Module: stack_control_fsm

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, stack capacity in entries (≥2); ALUW, 4, alu_op width (≤6); CW, $clog2(DEPTH+1), depth-count width (derived, not overridable).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op_valid  input  1  opcode offered this cycle.
REQ-005 opcode  input  6  stack-machine opcode: 0 NOP, 1 PUSH, 2 POP, 3..8 binary ALU ops, 9..63 illegal.
REQ-006 err_clr  input  1  clears the error condition.
REQ-007 op_ready  output  1  block accepts an opcode this cycle.
REQ-008 push  output  1  one-cycle push strobe to the stack.
REQ-009 pop  output  1  one-cycle pop strobe to the stack.
REQ-010 alu_en  output  1  ALU execute strobe.
REQ-011 alu_op  output  ALUW  ALU operation, valid while alu_en=1.
REQ-012 depth  output  CW  current stack occupancy.
REQ-013 full / empty  output  1 each  depth==DEPTH / depth==0.
REQ-014 error  output  1  error state active.
REQ-015 err_code  output  2  00 none, 01 overflow, 10 underflow, 11 illegal opcode.

Function
REQ-016 FSM states SHALL be IDLE, DO_PUSH, DO_POP, POP_A, POP_B, EXEC, PUSH_R, ERROR.
REQ-017 op_ready SHALL be 1 only in IDLE; an opcode is accepted on a clock edge where op_valid&op_ready=1.
REQ-018 The opcode SHALL be latched on acceptance; later opcode changes SHALL NOT affect the running operation.
REQ-019 NOP SHALL be accepted with no strobes, and the FSM SHALL remain in IDLE.
REQ-020 PUSH SHALL go IDLE→DO_PUSH→IDLE: push=1 for exactly the one cycle after acceptance, then depth+1.
REQ-021 POP SHALL go IDLE→DO_POP→IDLE: pop=1 for one cycle, then depth-1.
REQ-022 An ALU op SHALL sequence POP_A (pop=1) → POP_B (pop=1) → EXEC (alu_en=1) → PUSH_R (push=1) → IDLE, one cycle each, with op_ready low for 4 cycles and a net depth change of -1.
REQ-023 In EXEC, alu_op SHALL equal latched opcode[ALUW-1:0]; in all other cycles it SHALL be 0.
REQ-024 depth SHALL change only on push/pop strobes, by ±1, and SHALL never exceed DEPTH or wrap below 0.
REQ-025 Bounds SHALL be checked at acceptance: PUSH with depth==DEPTH → ERROR with code 01; POP with depth==0 → ERROR with code 10; ALU op with depth<2 → ERROR with code 10; illegal opcode → ERROR with code 11.
REQ-026 A failed check SHALL issue no strobe, and depth SHALL be unchanged.
REQ-027 ERROR SHALL hold error=1 and op_ready=0, and SHALL ignore op_valid until err_clr=1.
REQ-028 err_clr=1 in ERROR SHALL move to IDLE on the next edge, with err_code returning to 00 and depth preserved.
REQ-029 err_clr outside ERROR SHALL have no effect.
REQ-030 op_valid together with err_clr in ERROR SHALL NOT accept the opcode; the opcode is accepted no earlier than the following IDLE cycle.
REQ-031 At most one of push, pop, alu_en SHALL be high in any cycle.
REQ-032 All outputs except full and empty SHALL be registered or decoded from registered state only, with no combinational path from any input.

Reset
REQ-033 reset=0 SHALL asynchronously force IDLE, depth=0, push=pop=alu_en=0, alu_op=0, error=0, err_code=00, op_ready=1, empty=1, full=0.
REQ-034 Reset asserted mid-sequence (any non-IDLE state) SHALL abort the operation with no further strobes after release.
REQ-035 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-036 After reset, PUSH ×3 then opcode 3 → push at cycles 1,3,5; ALU op gives pop, pop, alu_en with alu_op=3, then push; final depth=2.
REQ-037 With DEPTH=4 and 4 PUSHes, a 5th PUSH → error=1, err_code=01, no push strobe, depth=4; err_clr → IDLE, err_code=00, depth=4.
REQ-038 With depth=1, opcode 5 → err_code=10, no pop strobe, depth=1; POP on empty → err_code=10.
REQ-039 opcode 12 → err_code=11; op_valid held high with err_clr → no acceptance that cycle, accepted next IDLE cycle.
REQ-040 reset pulsed during POP_B of an ALU op → all strobes 0, depth=0, op_ready=1 after release.
REQ-041 Opcode changed while in POP_A → EXEC still drives the latched alu_op; NOP → no strobes and depth unchanged.

Source files
------------

// File: rtl/stack_control_fsm.sv
// Sequencer for a hardware stack machine: issues push/pop/ALU strobes per opcode,
// tracks stack occupancy and traps overflow, underflow and illegal opcodes.
module stack_control_fsm #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ALUW  = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [5:0]      opcode,
  input  logic            err_clr,
  output logic            op_ready,
  output logic            push,
  output logic            pop,
  output logic            alu_en,
  output logic [ALUW-1:0] alu_op,
  output logic [CW-1:0]   depth,
  output logic            full,
  output logic            empty,
  output logic            error,
  output logic [1:0]      err_code
);

  localparam logic [5:0]    OP_NOP   = 6'd0;
  localparam logic [5:0]    OP_PUSH  = 6'd1;
  localparam logic [5:0]    OP_POP   = 6'd2;
  localparam logic [5:0]    OP_ALU_LO = 6'd3;
  localparam logic [5:0]    OP_ALU_HI = 6'd8;
  localparam logic [1:0]    ERR_NONE = 2'b00;
  localparam logic [1:0]    ERR_OVF  = 2'b01;
  localparam logic [1:0]    ERR_UNF  = 2'b10;
  localparam logic [1:0]    ERR_ILL  = 2'b11;
  localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO       = CW'(2);

  typedef enum logic [2:0] {
    IDLE, DO_PUSH, DO_POP, POP_A, POP_B, EXEC, PUSH_R, ERROR
  } state_t;

  state_t          state;
  logic [ALUW-1:0] op_q;
  logic            is_alu;

  assign is_alu = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);

  // Occupancy flags are the only outputs decoded from state rather than registered.
  assign full  = (depth == DEPTH_MAX);
  assign empty = (depth == '0);

  // Registered outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      depth    <= '0;
      push     <= 1'b0;
      pop      <= 1'b0;
      alu_en   <= 1'b0;
      alu_op   <= '0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      op_ready <= 1'b1;
    end else begin
      push     <= 1'b0;
      pop      <= 1'b0;
      alu_en   <= 1'b0;
      alu_op   <= '0;
      op_ready <= 1'b0;
      case (state)
        IDLE: begin
          op_ready <= 1'b1;
          if (op_valid) begin
            op_q <= opcode[ALUW-1:0];
            if (opcode == OP_NOP) begin
              state <= IDLE;
            end else if (opcode == OP_PUSH) begin
              if (depth == DEPTH_MAX) begin
                state    <= ERROR;
                error    <= 1'b1;
                err_code <= ERR_OVF;
                op_ready <= 1'b0;
              end else begin
                state    <= DO_PUSH;
                push     <= 1'b1;
                op_ready <= 1'b0;
              end
            end else if (opcode == OP_POP) begin
              if (depth == '0) begin
                state    <= ERROR;
                error    <= 1'b1;
                err_code <= ERR_UNF;
                op_ready <= 1'b0;
              end else begin
                state    <= DO_POP;
                pop      <= 1'b1;
                op_ready <= 1'b0;
              end
            end else if (is_alu) begin
              if (depth < TWO) begin
                state    <= ERROR;
                error    <= 1'b1;
                err_code <= ERR_UNF;
                op_ready <= 1'b0;
              end else begin
                state    <= POP_A;
                pop      <= 1'b1;
                op_ready <= 1'b0;
              end
            end else begin
              state    <= ERROR;
              error    <= 1'b1;
              err_code <= ERR_ILL;
              op_ready <= 1'b0;
            end
          end
        end
        DO_PUSH: begin
          depth    <= depth + ONE;
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        DO_POP: begin
          depth    <= depth - ONE;
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        POP_A: begin
          depth <= depth - ONE;
          state <= POP_B;
          pop   <= 1'b1;
        end
        POP_B: begin
          depth  <= depth - ONE;
          state  <= EXEC;
          alu_en <= 1'b1;
          alu_op <= op_q;
        end
        EXEC: begin
          state <= PUSH_R;
          push  <= 1'b1;
        end
        PUSH_R: begin
          depth    <= depth + ONE;
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        ERROR: begin
          if (err_clr) begin
            state    <= IDLE;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            op_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_control_fsm.sv
// Randomized scoreboard bench for stack_control_fsm: a stack-level model queues the
// expected strobe/error events per opcode and a monitor matches them as they appear.
module tb_stack_control_fsm;

  localparam int DEPTH = 4;
  localparam int ALUW  = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int K_PUSH = 0, K_POP = 1, K_ALU = 2, K_ERR = 3;

  typedef struct {
    int kind;
    int val;
    int dep;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            op_valid = 1'b0;
  logic [5:0]      opcode = '0;
  logic            err_clr = 1'b0;
  logic            op_ready, push, pop, alu_en, full, empty, error;
  logic [ALUW-1:0] alu_op;
  logic [CW-1:0]   depth;
  logic [1:0]      err_code;

  int   tests = 0;
  int   fails = 0;
  int   md = 0;
  ev_t  exp_q[$];

  stack_control_fsm #(.DEPTH(DEPTH), .ALUW(ALUW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .opcode(opcode), .err_clr(err_clr),
    .op_ready(op_ready), .push(push), .pop(pop), .alu_en(alu_en), .alu_op(alu_op),
    .depth(depth), .full(full), .empty(empty), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void add_ev(input int kind, input int val, input int dep);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.dep  = dep;
    exp_q.push_back(e);
  endfunction

  // Stack-level reference: what each opcode does to an abstract stack of md entries.
  function automatic bit model_issue(input int op);
    if (op == 0) return 1'b0;
    if (op == 1) begin
      if (md == DEPTH) begin add_ev(K_ERR, 1, md); return 1'b1; end
      add_ev(K_PUSH, 0, md);
      md = md + 1;
      return 1'b0;
    end
    if (op == 2) begin
      if (md == 0) begin add_ev(K_ERR, 2, md); return 1'b1; end
      add_ev(K_POP, 0, md);
      md = md - 1;
      return 1'b0;
    end
    if (op >= 3 && op <= 8) begin
      if (md < 2) begin add_ev(K_ERR, 2, md); return 1'b1; end
      add_ev(K_POP, 0, md);
      add_ev(K_POP, 0, md - 1);
      add_ev(K_ALU, op % (1 << ALUW), md - 2);
      add_ev(K_PUSH, 0, md - 2);
      md = md - 1;
      return 1'b0;
    end
    add_ev(K_ERR, 3, md);
    return 1'b1;
  endfunction

  // Monitor: matches each observed strobe or error entry against the scoreboard.
  initial begin
    logic prev_err;
    int   kind, val, nstb;
    ev_t  e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_err = 1'b0;
        continue;
      end
      nstb = int'(push) + int'(pop) + int'(alu_en);
      chk("strobe_onehot", int'(nstb <= 1), 1);
      if (!alu_en) chk("alu_op_idle_zero", alu_op, 0);
      chk("full_flag", full, int'(depth == CW'(DEPTH)));
      chk("empty_flag", empty, int'(depth == '0));
      if (error) chk("ready_in_error", op_ready, 0);
      if (push || pop || alu_en || (error && !prev_err)) begin
        kind = push ? K_PUSH : pop ? K_POP : alu_en ? K_ALU : K_ERR;
        val  = alu_en ? int'(alu_op) : (kind == K_ERR) ? int'(err_code) : 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_val", val, e.val);
          chk("event_depth", depth, e.dep);
        end
      end
      prev_err = error;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", op_ready, 1);
    chk("idle_depth", depth, md);
  endtask

  // Holds the block in ERROR with junk opcodes offered, then clears while offering a legal op.
  task automatic handle_err();
    int n;
    int nxt;
    bit dummy;
    n = 0;
    while (!error && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("error_seen", error, 1);
    repeat (2) begin
      op_valid = 1'b1;
      opcode   = 6'($urandom_range(0, 63));
      @(negedge clk);
      chk("error_hold", error, 1);
      chk("error_not_ready", op_ready, 0);
    end
    nxt = (md < DEPTH) ? 1 : 2;
    err_clr  = 1'b1;
    op_valid = 1'b1;
    opcode   = 6'(nxt);
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_error", error, 0);
    chk("clr_code", err_code, 0);
    chk("clr_ready", op_ready, 1);
    chk("clr_depth", depth, md);
    chk("clr_no_accept", int'(push | pop), 0);
    dummy = model_issue(nxt);
    @(posedge clk);
    #1 op_valid = 1'b0;
    opcode = 6'($urandom_range(0, 63));
  endtask

  task automatic do_op(input int op);
    bit is_err;
    wait_ready();
    op_valid = 1'b1;
    opcode   = 6'(op);
    err_clr  = 1'($urandom_range(0, 1));
    is_err   = model_issue(op);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    err_clr  = 1'b0;
    opcode   = 6'($urandom_range(0, 63));
    if (is_err) handle_err();
  endtask

  function automatic int rand_op();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 10) return 0;
    if (r < 45) return 1;
    if (r < 70) return 2;
    if (r < 92) return int'($urandom_range(3, 8));
    return int'($urandom_range(9, 63));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_strobes", int'({push, pop, alu_en}), 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_error", error, 0);
    chk("rst_code", err_code, 0);
    rst_n = 1'b1;

    // Three pushes then an ALU op, finishing at depth 2.
    repeat (3) do_op(1);
    do_op(3);
    wait_ready();
    chk("alu_final_depth", depth, 2);

    // Fill to capacity and overflow, then pop to empty and underflow.
    do_op(1); do_op(1);
    do_op(1);
    do_op(2); do_op(2); do_op(2); do_op(2);
    do_op(5);
    do_op(2); do_op(2);
    do_op(1);
    do_op(5);
    do_op(12);
    do_op(0);

    // Reset during POP_B of an ALU op aborts the remaining strobes.
    do_op(1); do_op(1);
    wait_ready();
    op_valid = 1'b1;
    opcode   = 6'd4;
    void'(model_issue(4));
    @(posedge clk);
    #1 op_valid = 1'b0;
    opcode = 6'd7;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    md = 0;
    #1;
    chk("mid_rst_strobes", int'({push, pop, alu_en}), 0);
    chk("mid_rst_depth", depth, 0);
    chk("mid_rst_ready", op_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", op_ready, 1);
    chk("post_rst_depth", depth, 0);

    for (int i = 0; i < 250; i++) do_op(rand_op());
    wait_ready();
    repeat (3) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
